// File: rtl/arm_boot_sequencer.sv
// -----------------------------------------------------------------------------
// arm_boot_sequencer
//
// Brings up the ARM test system. While arm_core is held in reset, a program
// image is streamed from a host word source into arm_memory through data
// port 2, one word per accepted handshake, at contiguous word addresses.
// After the last word a settle interval elapses, core reset is released and
// data port 2 is handed over to the core. Run cycles are counted until the
// core reports halted.
//
// Ports:
//   clk                : system clock, all logic on posedge
//   rst                : synchronous active-low reset
//   ld_valid/ld_data/ld_last/ld_ready : host image word handshake
//   core_mem_addr/core_mem_data_in/core_mem_write_en : core data-port request
//   core_halted        : core halted flag
//   core_rst           : active-high reset to arm_core
//   mem_addr/mem_data_in/mem_write_en : arm_memory data port 2
//   state              : LOAD=0, SETTLE=1, RUN=2, HALT=3, ERROR=4
//   load_count         : words written so far
//   run_cycles         : cycles spent in RUN (saturating)
//   err_overflow       : image exceeded MAX_WORDS
//   done               : core halted normally
// -----------------------------------------------------------------------------
module arm_boot_sequencer #(
    parameter logic [31:0] BASE_ADDR     = 32'h0,
    parameter int unsigned ADDR_STEP     = 4,
    parameter int unsigned MAX_WORDS     = 1024,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 32,
    localparam int unsigned LC_W         = $clog2(MAX_WORDS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [31:0]       core_mem_addr,
    input  logic [31:0]       core_mem_data_in,
    input  logic              core_mem_write_en,
    input  logic              core_halted,
    output logic              core_rst,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_data_in,
    output logic              mem_write_en,
    output logic [2:0]        state,
    output logic [LC_W-1:0]   load_count,
    output logic [CNT_W-1:0]  run_cycles,
    output logic              err_overflow,
    output logic              done
);

    localparam int unsigned SC_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_SETTLE = 3'd1,
        S_RUN    = 3'd2,
        S_HALT   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t           state_q;
    logic [31:0]      ld_addr_q;
    logic [31:0]      ld_wdata_q;
    logic             ld_we_q;
    logic [SC_W-1:0]  settle_cnt;
    logic [31:0]      next_addr;
    logic             accept;
    logic             core_owns_port;

    // Address of the word about to be accepted; wraps modulo 2^32.
    assign next_addr = BASE_ADDR + 32'(load_count) * 32'(ADDR_STEP);

    // Gated by rst so the host never sees ready during a reset cycle.
    assign ld_ready = rst && (state_q == S_LOAD);
    assign accept   = ld_valid && ld_ready;

    assign state          = state_q;
    assign core_owns_port = (state_q == S_RUN) || (state_q == S_HALT);

    // Once the core is running it drives port 2 directly, with no added latency.
    assign mem_addr     = core_owns_port ? core_mem_addr     : ld_addr_q;
    assign mem_data_in  = core_owns_port ? core_mem_data_in  : ld_wdata_q;
    assign mem_write_en = core_owns_port ? core_mem_write_en : ld_we_q;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_LOAD;
            core_rst     <= 1'b1;
            ld_addr_q    <= BASE_ADDR;
            ld_wdata_q   <= 32'h0;
            ld_we_q      <= 1'b0;
            settle_cnt   <= '0;
            load_count   <= '0;
            run_cycles   <= '0;
            err_overflow <= 1'b0;
            done         <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse; only an accept re-arms it.
            ld_we_q <= 1'b0;

            case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        ld_addr_q  <= next_addr;
                        ld_wdata_q <= ld_data;
                        ld_we_q    <= 1'b1;
                        load_count <= load_count + LC_W'(1);
                        // ld_last wins over capacity: a full image ending exactly
                        // at MAX_WORDS is legal.
                        if (ld_last) begin
                            state_q <= S_SETTLE;
                        end else if (load_count == LC_W'(MAX_WORDS - 1)) begin
                            state_q      <= S_ERROR;
                            err_overflow <= 1'b1;
                        end
                    end
                end

                S_SETTLE: begin
                    // The first SETTLE cycle carries the final write pulse; the
                    // count then adds SETTLE_CYCLES quiet cycles before release.
                    if (settle_cnt == SC_W'(SETTLE_CYCLES)) begin
                        state_q  <= S_RUN;
                        core_rst <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + SC_W'(1);
                    end
                end

                S_RUN: begin
                    if (run_cycles != {CNT_W{1'b1}}) begin
                        run_cycles <= run_cycles + CNT_W'(1);
                    end
                    if (core_halted) begin
                        state_q <= S_HALT;
                        done    <= 1'b1;
                    end
                end

                S_HALT: begin
                    // Terminal until reset.
                end

                S_ERROR: begin
                    // Terminal until reset; core stays in reset.
                end

                default: begin
                    state_q      <= S_ERROR;
                    err_overflow <= 1'b1;
                    core_rst     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_arm_boot_sequencer
//
// Drives three sequencer instances from one shared stimulus stream:
//   u0 : MAX_WORDS=1024 (default configuration)
//   u1 : MAX_WORDS=4    (overflow case)
//   u2 : MAX_WORDS=1, CNT_W=4 (single-word image, run counter saturation)
// A phase-level model predicts every output each cycle; directed literal
// checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_arm_boot_sequencer;

    localparam int SETTLE = 2;

    logic        clk;
    logic        rst;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic [31:0] core_mem_addr;
    logic [31:0] core_mem_data_in;
    logic        core_mem_write_en;
    logic        core_halted;

    logic        ld_ready_o [3];
    logic        core_rst_o [3];
    logic [31:0] mem_addr_o [3];
    logic [31:0] mem_data_o [3];
    logic        mem_we_o   [3];
    logic [2:0]  state_o    [3];
    logic [31:0] lc_o       [3];
    logic [31:0] rc_o       [3];
    logic        err_o      [3];
    logic        done_o     [3];

    logic [10:0] lc0;
    logic [2:0]  lc1;
    logic [0:0]  lc2;
    logic [3:0]  rc2;

    assign lc_o[0] = 32'(lc0);
    assign lc_o[1] = 32'(lc1);
    assign lc_o[2] = 32'(lc2);
    assign rc_o[2] = 32'(rc2);

    arm_boot_sequencer #(.MAX_WORDS(1024), .SETTLE_CYCLES(SETTLE), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready_o[0]), .core_mem_addr(core_mem_addr),
        .core_mem_data_in(core_mem_data_in), .core_mem_write_en(core_mem_write_en),
        .core_halted(core_halted), .core_rst(core_rst_o[0]), .mem_addr(mem_addr_o[0]),
        .mem_data_in(mem_data_o[0]), .mem_write_en(mem_we_o[0]), .state(state_o[0]),
        .load_count(lc0), .run_cycles(rc_o[0]), .err_overflow(err_o[0]), .done(done_o[0]));

    arm_boot_sequencer #(.MAX_WORDS(4), .SETTLE_CYCLES(SETTLE), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready_o[1]), .core_mem_addr(core_mem_addr),
        .core_mem_data_in(core_mem_data_in), .core_mem_write_en(core_mem_write_en),
        .core_halted(core_halted), .core_rst(core_rst_o[1]), .mem_addr(mem_addr_o[1]),
        .mem_data_in(mem_data_o[1]), .mem_write_en(mem_we_o[1]), .state(state_o[1]),
        .load_count(lc1), .run_cycles(rc_o[1]), .err_overflow(err_o[1]), .done(done_o[1]));

    arm_boot_sequencer #(.MAX_WORDS(1), .SETTLE_CYCLES(SETTLE), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready_o[2]), .core_mem_addr(core_mem_addr),
        .core_mem_data_in(core_mem_data_in), .core_mem_write_en(core_mem_write_en),
        .core_halted(core_halted), .core_rst(core_rst_o[2]), .mem_addr(mem_addr_o[2]),
        .mem_data_in(mem_data_o[2]), .mem_write_en(mem_we_o[2]), .state(state_o[2]),
        .load_count(lc2), .run_cycles(rc2), .err_overflow(err_o[2]), .done(done_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    localparam int P_LOAD = 0, P_SETTLE = 1, P_RUN = 2, P_HALT = 3, P_ERROR = 4;

    int          max_words [3] = '{1024, 4, 1};
    logic [31:0] cnt_max   [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};

    bit          model_on = 1'b0;
    int          cyc = 0;
    int          m_words     [3];
    bit          m_last      [3];
    bit          m_ovf       [3];
    bit          m_halt      [3];
    int          m_run_start [3];
    logic [31:0] m_rc        [3];
    logic [31:0] m_addr      [3];
    logic [31:0] m_data      [3];
    bit          m_we        [3];

    // Phase of instance k during cycle c, derived from the image history.
    function automatic int phase_of(input int k, input int c);
        if (m_ovf[k])        return P_ERROR;
        if (!m_last[k])      return P_LOAD;
        if (m_halt[k])       return P_HALT;
        if (c < m_run_start[k]) return P_SETTLE;
        return P_RUN;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int ph;
            ph = phase_of(k, cyc);
            if (!rst) begin
                m_words[k] = 0;  m_last[k] = 0;  m_ovf[k] = 0;  m_halt[k] = 0;
                m_run_start[k] = 0;  m_rc[k] = 0;
                m_addr[k] = 32'h0;  m_data[k] = 32'h0;  m_we[k] = 0;
            end else begin
                m_we[k] = 0;
                if (ph == P_LOAD && ld_valid) begin
                    m_addr[k] = 32'(m_words[k] * 4);
                    m_data[k] = ld_data;
                    m_we[k]   = 1;
                    m_words[k]++;
                    if (ld_last) begin
                        m_last[k] = 1;
                        // pulse in cycle cyc+1, then SETTLE quiet cycles
                        m_run_start[k] = cyc + 2 + SETTLE;
                    end else if (m_words[k] == max_words[k]) begin
                        m_ovf[k] = 1;
                    end
                end
                if (ph == P_RUN) begin
                    if (m_rc[k] != cnt_max[k]) m_rc[k] = m_rc[k] + 1;
                    if (core_halted) m_halt[k] = 1;
                end
            end
        end
        if (!rst) model_on = 1'b1;
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare of every instance against the model.
    initial forever begin
        @(negedge clk);
        if (model_on) begin
            for (int k = 0; k < 3; k++) begin
                int  ph;
                bit  core_side;
                ph = phase_of(k, cyc);
                core_side = (ph == P_RUN) || (ph == P_HALT);
                check($sformatf("u%0d.state", k),    64'(state_o[k]),    64'(ph));
                check($sformatf("u%0d.ld_ready", k), 64'(ld_ready_o[k]), 64'((ph == P_LOAD) && rst));
                check($sformatf("u%0d.core_rst", k), 64'(core_rst_o[k]), 64'(!core_side));
                check($sformatf("u%0d.mem_addr", k), 64'(mem_addr_o[k]),
                      64'(core_side ? core_mem_addr : m_addr[k]));
                check($sformatf("u%0d.mem_data", k), 64'(mem_data_o[k]),
                      64'(core_side ? core_mem_data_in : m_data[k]));
                check($sformatf("u%0d.mem_we", k),   64'(mem_we_o[k]),
                      64'(core_side ? core_mem_write_en : m_we[k]));
                check($sformatf("u%0d.load_count", k), 64'(lc_o[k]), 64'(m_words[k]));
                check($sformatf("u%0d.run_cycles", k), 64'(rc_o[k]), 64'(m_rc[k]));
                check($sformatf("u%0d.err", k),  64'(err_o[k]),  64'(ph == P_ERROR));
                check($sformatf("u%0d.done", k), 64'(done_o[k]), 64'(ph == P_HALT));
            end
        end
    end

    // Write pulse log (loader-side writes only).
    logic [31:0] wlog_a0[$], wlog_d0[$], wlog_a1[$];
    initial forever begin
        @(negedge clk);
        if (model_on && rst) begin
            if (mem_we_o[0] && !(state_o[0] inside {3'd2, 3'd3})) begin
                wlog_a0.push_back(mem_addr_o[0]);
                wlog_d0.push_back(mem_data_o[0]);
            end
            if (mem_we_o[1] && !(state_o[1] inside {3'd2, 3'd3}))
                wlog_a1.push_back(mem_addr_o[1]);
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid = 1'b0;  ld_last = 1'b0;  ld_data = 32'h0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        ld_valid = 1'b1;  ld_data = d;  ld_last = last;
        step();
        idle_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        wlog_a0.delete();  wlog_d0.delete();  wlog_a1.delete();
    endtask

    logic [31:0] img [3] = '{32'hE3A0_0001, 32'hE3A0_1002, 32'hE080_2001};
    bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        core_mem_addr = 32'h0;  core_mem_data_in = 32'h0;
        core_mem_write_en = 1'b0;  core_halted = 1'b0;
        step();
        step();
        rst = 1'b1;
        check("reset.state", 64'(state_o[0]), 64'd0);
        check("reset.core_rst", 64'(core_rst_o[0]), 64'd1);
        check("reset.load_count", 64'(lc_o[0]), 64'd0);
        wlog_a0.delete();  wlog_d0.delete();  wlog_a1.delete();

        // S1: three-word image, then run and halt on the 10th RUN cycle.
        send(img[0], 1'b0);
        send(img[1], 1'b0);
        send(img[2], 1'b1);
        // now in the final write pulse cycle
        check("s1.pulse_we",   64'(mem_we_o[0]), 64'd1);
        check("s1.pulse_addr", 64'(mem_addr_o[0]), 64'h8);
        check("s1.load_count", 64'(lc_o[0]), 64'd3);
        ld_valid = 1'b1;  ld_data = 32'h5555_5555;  // ignored outside LOAD
        step();
        check("s1.settle_we", 64'(mem_we_o[0]), 64'd0);
        step();
        check("s1.core_rst_held", 64'(core_rst_o[0]), 64'd1);
        idle_inputs();
        step();
        check("s1.run_state", 64'(state_o[0]), 64'd2);
        check("s1.core_rst_low", 64'(core_rst_o[0]), 64'd0);
        core_mem_addr = 32'h100;  core_mem_data_in = 32'hDEAD_BEEF;  core_mem_write_en = 1'b1;
        #1;
        check("s1.mux_addr", 64'(mem_addr_o[0]), 64'h100);
        check("s1.mux_data", 64'(mem_data_o[0]), 64'hDEAD_BEEF);
        check("s1.mux_we",   64'(mem_we_o[0]), 64'd1);
        for (int i = 0; i < 9; i++) step();
        core_halted = 1'b1;
        step();
        core_halted = 1'b0;
        core_mem_write_en = 1'b0;
        check("s1.halt_state", 64'(state_o[0]), 64'd3);
        check("s1.run_cycles", 64'(rc_o[0]), 64'd10);
        check("s1.done", 64'(done_o[0]), 64'd1);
        step();  step();  step();
        check("s1.run_frozen", 64'(rc_o[0]), 64'd10);
        check("s1.nwrites", 64'(wlog_a0.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < wlog_a0.size()) begin
                check($sformatf("s1.wr_addr%0d", i), 64'(wlog_a0[i]), 64'(i * 4));
                check($sformatf("s1.wr_data%0d", i), 64'(wlog_d0[i]), 64'(img[i]));
            end
        end

        // S2: gapped valid pattern, exactly three contiguous writes.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ld_valid = pat[i];  ld_last = (i == 5);  ld_data = 32'h1000 + 32'(i);
            step();
        end
        idle_inputs();
        step();  step();
        check("s2.nwrites", 64'(wlog_a0.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < wlog_a0.size())
                check($sformatf("s2.wr_addr%0d", i), 64'(wlog_a0[i]), 64'(i * 4));
        step();  step();  step();

        // S3: five words without ld_last; core_halted held high during load.
        do_reset();
        core_halted = 1'b1;
        for (int i = 0; i < 5; i++) send(32'hA000 + 32'(i), 1'b0);
        step();  step();
        check("s3.u1_state", 64'(state_o[1]), 64'd4);
        check("s3.u1_err", 64'(err_o[1]), 64'd1);
        check("s3.u1_ready", 64'(ld_ready_o[1]), 64'd0);
        check("s3.u1_core_rst", 64'(core_rst_o[1]), 64'd1);
        check("s3.u1_load_count", 64'(lc_o[1]), 64'd4);
        check("s3.u1_nwrites", 64'(wlog_a1.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < wlog_a1.size())
                check($sformatf("s3.u1_wr_addr%0d", i), 64'(wlog_a1[i]), 64'(i * 4));
        check("s3.u0_load_count", 64'(lc_o[0]), 64'd5);
        core_halted = 1'b0;

        // S4: reset after two words; load restarts at BASE_ADDR.
        do_reset();
        send(32'hB000, 1'b0);
        send(32'hB001, 1'b0);
        rst = 1'b0;  ld_valid = 1'b1;  ld_data = 32'hBBBB;
        #1;
        check("s4.ready_in_reset", 64'(ld_ready_o[0]), 64'd0);
        step();
        rst = 1'b1;
        idle_inputs();
        check("s4.state", 64'(state_o[0]), 64'd0);
        check("s4.load_count", 64'(lc_o[0]), 64'd0);
        check("s4.core_rst", 64'(core_rst_o[0]), 64'd1);
        send(32'hC0DE, 1'b0);
        check("s4.restart_addr", 64'(mem_addr_o[0]), 64'h0);
        check("s4.restart_we", 64'(mem_we_o[0]), 64'd1);
        check("s4.restart_data", 64'(mem_data_o[0]), 64'hC0DE);

        // S5: single-word image on MAX_WORDS=1; core_halted ignored in SETTLE;
        // long run saturates the 4-bit counter of u2.
        do_reset();
        core_halted = 1'b1;
        send(32'h1234_5678, 1'b1);
        check("s5.u2_state", 64'(state_o[2]), 64'd1);
        check("s5.u2_err", 64'(err_o[2]), 64'd0);
        check("s5.u2_addr", 64'(mem_addr_o[2]), 64'h0);
        step();  step();
        core_halted = 1'b0;
        step();
        check("s5.u2_run", 64'(state_o[2]), 64'd2);
        for (int i = 0; i < 20; i++) step();
        check("s5.u2_saturated", 64'(rc_o[2]), 64'd15);
        check("s5.u0_run_cycles", 64'(rc_o[0]), 64'd20);
        core_halted = 1'b1;
        step();
        core_halted = 1'b0;
        step();  step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
